// File: rtl/out_display.sv
`default_nettype none
// ---------------------------------------------------------------------------
// out_display: latches the bus byte, converts it to sign + 3 BCD digits
// (double-dabble), and scans a 4-digit multiplexed 7-segment display.
// Rev 1.0
// ---------------------------------------------------------------------------
module out_display #(
  parameter int SCAN_DIV = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [0:7] data_in,
  input  logic       wo,
  input  logic       sgn,
  output logic [0:7] data_out,
  output logic       busy,
  output logic [0:6] seg_out,
  output logic [0:3] dig_en
);

  localparam int PW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    data_q, data_d;
  logic          sgn_q, sgn_d;
  logic [7:0]    mag_q, mag_d;
  logic          negp_q, negp_d;
  logic [11:0]   bcd_q, bcd_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [11:0]   digits_q, digits_d;
  logic          neg_q, neg_d;
  logic          busy_q, busy_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    dig_en_q, dig_en_d;
  logic [6:0]    seg_q, seg_d;
  logic [11:0]   bcd_adj;
  logic          scan_wrap;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    sgn_d    = sgn_q;
    mag_d    = mag_q;
    negp_d   = negp_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    neg_d    = neg_q;
    busy_d   = busy_q;

    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    case (state_q)
      S_LOAD: begin
        negp_d  = sgn_q & data_q[7];
        mag_d   = negp_d ? (~data_q + 8'd1) : data_q;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
        cnt_d          = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = S_DONE;
      end
      S_DONE: begin
        digits_d = bcd_q;
        neg_d    = negp_q;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: ;
    endcase

    // A new write wins over whatever conversion is in flight.
    if (wo) begin
      data_d  = data_in;
      sgn_d   = sgn;
      state_d = S_LOAD;
      busy_d  = 1'b1;
    end
  end

  always_comb begin
    scan_wrap = (presc_q == PW'(SCAN_DIV - 1));
    presc_d   = scan_wrap ? '0 : presc_q + PW'(1);
    idx_d     = scan_wrap ? idx_q + 2'd1 : idx_q;
    dig_en_d  = 4'b1000 >> idx_d;
    seg_d     = '0;
    case (idx_d)
      2'd0: seg_d = neg_q ? 7'b0000001 : 7'b0000000;
      2'd1: seg_d = (digits_q[11:8] == 4'd0) ? 7'b0000000 : seg7(digits_q[11:8]);
      2'd2: seg_d = (digits_q[11:4] == 8'd0) ? 7'b0000000 : seg7(digits_q[7:4]);
      default: seg_d = seg7(digits_q[3:0]);
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      sgn_q    <= 1'b0;
      mag_q    <= '0;
      negp_q   <= 1'b0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      presc_q  <= '0;
      idx_q    <= '0;
      dig_en_q <= 4'b1000;
      seg_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      sgn_q    <= sgn_d;
      mag_q    <= mag_d;
      negp_q   <= negp_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      dig_en_q <= dig_en_d;
      seg_q    <= seg_d;
    end
  end

  assign data_out = data_q;
  assign busy     = busy_q;
  assign seg_out  = seg_q;
  assign dig_en   = dig_en_q;

endmodule
`default_nettype wire

// File: tb/tb_out_display.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_out_display: directed-vector self-checking bench for out_display.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_out_display;

  localparam logic [6:0] BLK = 7'b0000000;
  localparam logic [6:0] MIN = 7'b0000001;
  localparam logic [6:0] D0  = 7'b1111110;
  localparam logic [6:0] D1  = 7'b0110000;
  localparam logic [6:0] D2  = 7'b1101101;
  localparam logic [6:0] D5  = 7'b1011011;
  localparam logic [6:0] D7  = 7'b1110000;
  localparam logic [6:0] D8  = 7'b1111111;

  logic       clk;
  logic       clr;
  logic [0:7] data_in;
  logic       wo;
  logic       sgn;
  logic [0:7] data_out;
  logic       busy;
  logic [0:6] seg_out;
  logic [0:3] dig_en;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon200 = 0;
  bit seen200 = 0;

  out_display #(.SCAN_DIV(4)) dut (
    .clk      (clk),
    .clr      (clr),
    .data_in  (data_in),
    .wo       (wo),
    .sgn      (sgn),
    .data_out (data_out),
    .busy     (busy),
    .seg_out  (seg_out),
    .dig_en   (dig_en)
  );

  always #5 clk = ~clk;

  // Any '2' glyph while the 200 -> 7 overwrite is in flight means 200 leaked.
  always @(negedge clk) if (mon200 && seg_out == D2) seen200 = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] d, input logic s);
    @(negedge clk);
    data_in = d;
    sgn     = s;
    wo      = 1'b1;
    @(negedge clk);
    wo      = 1'b0;
  endtask

  task automatic count_busy(input string tag, input int exp);
    int b = 0;
    while (busy === 1'b1 && b < 40) begin
      b++;
      @(negedge clk);
    end
    chk(tag, b, exp);
  endtask

  task automatic wait_dig(input string tag, input logic [3:0] want);
    int g = 0;
    while (dig_en !== want && g < 64) begin
      @(negedge clk);
      g++;
    end
    if (dig_en !== want) chk({tag, "_timeout"}, dig_en, want);
  endtask

  task automatic check_disp(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] exp_s [4];
    exp_s[0] = e0; exp_s[1] = e1; exp_s[2] = e2; exp_s[3] = e3;
    wait_dig(tag, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      wait_dig(tag, 4'(4'b1000 >> k));
      chk($sformatf("%s_idx%0d", tag, k), seg_out, exp_s[k]);
    end
  endtask

  initial begin
    clk = 0; clr = 0; wo = 0; data_in = '0; sgn = 0;
    repeat (3) @(negedge clk);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dig_en", dig_en, 4'b1000);
    chk("rst_seg", seg_out, BLK);

    // Scan order and dwell from reset release, sampled once per clock.
    clr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("scan%0d", i), dig_en, 4'(4'b1000 >> ((i / 4) % 4)));
      @(negedge clk);
    end
    check_disp("rst_disp", BLK, BLK, BLK, D0);

    write_byte(8'd255, 1'b0);
    chk("u255_data_out", data_out, 8'hFF);
    count_busy("u255_busy_len", 10);
    check_disp("u255", BLK, D2, D5, D5);

    write_byte(8'hFF, 1'b1);
    count_busy("m1_busy_len", 10);
    check_disp("m1", MIN, BLK, BLK, D1);

    write_byte(8'h80, 1'b1);
    chk("m128_data_out", data_out, 8'h80);
    count_busy("m128_busy_len", 10);
    check_disp("m128", MIN, D1, D2, D8);

    write_byte(8'h00, 1'b1);
    count_busy("z_busy_len", 10);
    check_disp("zero", BLK, BLK, BLK, D0);

    mon200 = 1'b1;
    write_byte(8'd200, 1'b0);
    repeat (4) @(negedge clk);
    write_byte(8'd7, 1'b0);
    chk("ovr_data_out", data_out, 8'h07);
    count_busy("ovr_busy_len", 10);
    check_disp("ovr7", BLK, BLK, BLK, D7);
    mon200 = 1'b0;
    chk("ovr_no200", seen200, 1'b0);

    // Asynchronous clear in the middle of the shift phase.
    write_byte(8'd123, 1'b0);
    repeat (3) @(negedge clk);
    #2 clr = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_data_out", data_out, 8'h00);
    chk("arst_dig_en", dig_en, 4'b1000);
    chk("arst_seg", seg_out, BLK);
    @(negedge clk);
    clr = 1'b1;
    repeat (12) @(negedge clk);
    chk("arst_busy_after", busy, 1'b0);
    check_disp("arst_disp", BLK, BLK, BLK, D0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
